multicycle_controller: RTL and testbench
========================================

// Module: multicycle_controller
// PURPOSE
//  Multi-cycle RV32I main control FSM. Fetch/decode/execute/memory/writeback sequencing with a memory ready handshake.
//  Timeout watchdog on memory accesses; sticky error state for illegal opcodes or timeouts.
//  Sits between the instruction register and the shared datapath. Drives regfile, ALU-decoder, memory and PC/IR enables.
// PARAMETERS
//  TIMEOUT_CYC  16  max cycles to wait for mem_ready in FETCH/MEM; 0 = watchdog disabled
//  CNT_W        $clog2(TIMEOUT_CYC+1)  localparam, watchdog counter width (min 1)
// PORTS
//  clk          in   1  single clock, all state updates on posedge
//  reset        in   1  synchronous, active-high
//  opcode       in   7  instr[6:0] from instruction register
//  mem_ready    in   1  memory completes current access this cycle
//  pc_write     out  1  PC <= next PC (PC+4, or branch/jump target per pc_src)
//  pc_src       out  1  0: PC+4; 1: ALU/branch target
//  ir_write     out  1  instruction register load
//  i_or_d       out  1  0: mem address = PC; 1: mem address = ALU result
//  alu_src      out  1  0: rs2; 1: immediate
//  mem_to_reg   out  1  1: writeback data from memory
//  reg_write    out  1  regfile write enable
//  mem_read     out  1  memory read request
//  mem_write    out  1  memory write request
//  alu_op       out  2  00 add (LW/SW); 01 branch compare; 10 funct-decoded (R/I)
//  branch       out  1  branch compare cycle; PC updated only if ALU zero
//  jump         out  1  JAL/JALR cycle (0 without CTRL_JAL_EN)
//  error        out  1  sticky: controller halted in ERR
//  state        out  3  current state encoding, debug
// BEHAVIOUR
//  States: FETCH=0 DECODE=1 EXEC=2 MEM=3 WB=4 ERR=5; codes 6/7 -> ERR next cycle.
//  Reset: state=FETCH, opcode_q=0, wdog=0. While reset is high, all outputs are forced to 0 and state reads 0.
//  Outputs are Moore: a function of state and opcode_q only.
//  FETCH: mem_read=1, i_or_d=0.
//   - While mem_ready=0: hold; wdog++.
//   - On mem_ready=1: ir_write=1, pc_write=1, pc_src=0 -> DECODE, wdog=0.
//  DECODE: opcode_q <= opcode.
//   - Legal opcodes: 0110011 R, 0010011 I, 0000011 LW, 0100011 SW, 1100011 BR. Next state -> EXEC.
//   - Any other opcode -> ERR.
//  EXEC:
//   - R: alu_src=0, alu_op=10 -> WB.
//   - I: alu_src=1, alu_op=10 -> WB.
//   - LW/SW: alu_src=1, alu_op=00 -> MEM.
//   - BR: alu_src=0, alu_op=01, branch=1, pc_src=1 -> FETCH. Datapath gates pc_write with zero.
//  MEM: i_or_d=1; mem_read=1 (LW) or mem_write=1 (SW); hold and wdog++ until mem_ready.
//   - LW + ready -> WB.
//   - SW + ready -> FETCH.
//  WB: reg_write=1; mem_to_reg=1 iff LW -> FETCH.
//  Instruction latency: R/I 4 cycles, BR 3, SW 4, LW 5 (zero wait states). Each wait cycle adds 1.
//  Watchdog: if TIMEOUT_CYC>0 and wdog reaches TIMEOUT_CYC with mem_ready still 0 -> ERR. Requests drop next cycle.
//   - mem_ready=1 on the same cycle the count is reached: completes normally; ready wins.
//   - wdog clears on every state change; it never counts outside FETCH/MEM.
//  ERR: error=1, all other outputs 0. Held until reset.
//  Reset mid-access (any state): next cycle FETCH, any pending mem request is dropped, opcode_q cleared.
//  mem_ready outside FETCH/MEM is ignored.
// CONFIGURATION
//  CTRL_JAL_EN defined:
//   - 1101111 JAL and 1100111 JALR become legal.
//   - EXEC: jump=1, alu_src=1 (JALR), pc_write=1, pc_src=1 -> WB.
//   - WB: reg_write=1, mem_to_reg=0; datapath writes PC+4.
//  CTRL_JAL_EN undefined: both opcodes are illegal (DECODE -> ERR); jump is tied to 0.
// TESTING
//  1. R-type add, mem_ready=1 always -> states 0,1,2,4,0. reg_write=1 only in WB; alu_op=10 in EXEC.
//  2. LW, mem_ready low 3 cycles in MEM -> MEM held 4 cycles (mem_read=1, i_or_d=1). WB has mem_to_reg=1. Total 8 cycles.
//  3. SW then BR back-to-back -> SW: mem_write=1 one cycle, no WB. BR: branch=1, alu_op=01, 3 cycles.
//  4. TIMEOUT_CYC=4, mem_ready held 0 in FETCH -> ERR after 4 wait cycles. error=1 sticky. Reset -> FETCH, error=0.
//  5. Opcode 1101111: macro off -> ERR after DECODE. Macro on -> EXEC jump=1, pc_write=1, then WB reg_write=1.
//  6. Reset asserted in MEM during SW wait -> all outputs 0 while asserted. FETCH on the first cycle after release; no mem_write.

Source files
------------

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I main control FSM: fetch/decode/execute/memory/writeback with memory-ready watchdog and sticky ERR.
// Optional JAL/JALR support under `CTRL_JAL_EN; without it both opcodes decode as illegal and jump stays 0.
module multicycle_controller #(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_src,
  output logic       ir_write,
  output logic       i_or_d,
  output logic       alu_src,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic [1:0] alu_op,
  output logic       branch,
  output logic       jump,
  output logic       error,
  output logic [2:0] state
);

  localparam int CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam bit WDOG_EN = (TIMEOUT_CYC > 0);
  localparam logic [CNT_W-1:0] WDOG_LAST = WDOG_EN ? CNT_W'(TIMEOUT_CYC - 1) : '0;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_ERR    = 3'd5
  } state_e;

  state_e           state_q, state_d;
  logic [6:0]       opcode_q, opcode_d;
  logic [CNT_W-1:0] wdog_q, wdog_d;
  logic             wdog_expired;
  logic [CNT_W-1:0] wdog_inc;

  function automatic logic op_legal(input logic [6:0] op);
    case (op)
      OP_R, OP_I, OP_LW, OP_SW, OP_BR: op_legal = 1'b1;
`ifdef CTRL_JAL_EN
      OP_JAL, OP_JALR:                 op_legal = 1'b1;
`endif
      default:                         op_legal = 1'b0;
    endcase
  endfunction

  // Watchdog fires on the last permitted wait cycle only if ready is still low.
  assign wdog_expired = WDOG_EN && (wdog_q == WDOG_LAST);
  assign wdog_inc     = WDOG_EN ? wdog_q + 1'b1 : '0;

  always_comb begin
    state_d  = state_q;
    opcode_d = opcode_q;
    wdog_d   = '0;
    case (state_q)
      S_FETCH: begin
        if (mem_ready)         state_d = S_DECODE;
        else if (wdog_expired) state_d = S_ERR;
        else                   wdog_d  = wdog_inc;
      end
      S_DECODE: begin
        opcode_d = opcode;
        state_d  = op_legal(opcode) ? S_EXEC : S_ERR;
      end
      S_EXEC: begin
        case (opcode_q)
          OP_R, OP_I:   state_d = S_WB;
          OP_LW, OP_SW: state_d = S_MEM;
          OP_BR:        state_d = S_FETCH;
`ifdef CTRL_JAL_EN
          OP_JAL, OP_JALR: state_d = S_WB;
`endif
          default:      state_d = S_ERR;
        endcase
      end
      S_MEM: begin
        if (mem_ready)         state_d = (opcode_q == OP_LW) ? S_WB : S_FETCH;
        else if (wdog_expired) state_d = S_ERR;
        else                   wdog_d  = wdog_inc;
      end
      S_WB:    state_d = S_FETCH;
      S_ERR:   state_d = S_ERR;
      default: state_d = S_ERR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_FETCH;
      opcode_q <= '0;
      wdog_q   <= '0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      wdog_q   <= wdog_d;
    end
  end

  // IR/PC load in FETCH is qualified by mem_ready so wait cycles never advance the PC.
  always_comb begin
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    ir_write   = 1'b0;
    i_or_d     = 1'b0;
    alu_src    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    alu_op     = 2'b00;
    branch     = 1'b0;
    jump       = 1'b0;
    error      = 1'b0;
    state      = 3'd0;
    if (!reset) begin
      state = state_q;
      case (state_q)
        S_FETCH: begin
          mem_read = 1'b1;
          ir_write = mem_ready;
          pc_write = mem_ready;
        end
        S_EXEC: begin
          case (opcode_q)
            OP_R: alu_op = 2'b10;
            OP_I: begin
              alu_src = 1'b1;
              alu_op  = 2'b10;
            end
            OP_LW, OP_SW: alu_src = 1'b1;
            OP_BR: begin
              alu_op   = 2'b01;
              branch   = 1'b1;
              pc_src   = 1'b1;
              pc_write = 1'b1;
            end
`ifdef CTRL_JAL_EN
            OP_JAL, OP_JALR: begin
              jump     = 1'b1;
              alu_src  = (opcode_q == OP_JALR);
              pc_write = 1'b1;
              pc_src   = 1'b1;
            end
`endif
            default: ;
          endcase
        end
        S_MEM: begin
          i_or_d    = 1'b1;
          mem_read  = (opcode_q == OP_LW);
          mem_write = (opcode_q == OP_SW);
        end
        S_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = (opcode_q == OP_LW);
        end
        S_ERR:   error = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized bench for multicycle_controller: per-cycle expected control vectors from an instruction-level model, checked by a scoreboard monitor.
module tb_multicycle_controller;

  localparam int TO = 4;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  typedef struct packed {
    logic [2:0] st;
    logic       err, jmp, br;
    logic [1:0] aop;
    logic       mw, mr, rw, m2r, asrc, iod, irw, psrc, pw;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] opcode = '0;
  logic       mem_ready = 1'b0;
  logic       pc_write, pc_src, ir_write, i_or_d, alu_src, mem_to_reg, reg_write;
  logic       mem_read, mem_write, branch, jump, error;
  logic [1:0] alu_op;
  logic [2:0] state;
  vec_t       act;

  int checks = 0;
  int failures = 0;
  vec_t  exp_q[$];
  string tag_q[$];

  multicycle_controller #(.TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_src(pc_src), .ir_write(ir_write), .i_or_d(i_or_d),
    .alu_src(alu_src), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .mem_read(mem_read), .mem_write(mem_write), .alu_op(alu_op), .branch(branch),
    .jump(jump), .error(error), .state(state)
  );

  always #5 clk = ~clk;

  assign act = {state, error, jump, branch, alu_op, mem_write, mem_read, reg_write,
                mem_to_reg, alu_src, i_or_d, ir_write, pc_src, pc_write};

  always @(negedge clk) begin
    vec_t  e;
    string t;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      checks++;
      if (act !== e) begin
        failures++;
        $display("FAIL %s t=%0t got=%h exp=%h", t, $time, act, e);
      end
    end
  end

  function automatic vec_t blank(input logic [2:0] st);
    vec_t v;
    v = '0;
    v.st = st;
    return v;
  endfunction

  function automatic logic legal(input logic [6:0] op);
    if (op == OP_R || op == OP_I || op == OP_LW || op == OP_SW || op == OP_BR) return 1'b1;
`ifdef CTRL_JAL_EN
    if (op == OP_JAL || op == OP_JALR) return 1'b1;
`endif
    return 1'b0;
  endfunction

  task automatic step(input logic [6:0] op, input logic rdy, input vec_t e, input string tag);
    opcode    = op;
    mem_ready = rdy;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    for (int i = 0; i < n; i++) step(7'($urandom), 1'($urandom), blank(3'd0), "reset_outputs");
    reset = 1'b0;
  endtask

  task automatic err_tail();
    vec_t v;
    v = blank(3'd5);
    v.err = 1'b1;
    for (int i = 0; i < 3; i++) step(7'($urandom), 1'($urandom), v, "err_sticky");
    do_reset($urandom_range(1, 2));
  endtask

  // One instruction: fw/mw = wait cycles before mem_ready in FETCH/MEM; >= TO means timeout.
  task automatic run_instr(input logic [6:0] op, input int fw, input int mw);
    vec_t v;
    for (int i = 0; i < fw; i++) begin
      v = blank(3'd0);
      v.mr = 1'b1;
      step(7'($urandom), 1'b0, v, "fetch_wait");
      if (i == TO - 1) begin
        err_tail();
        return;
      end
    end
    v = blank(3'd0);
    v.mr = 1'b1; v.irw = 1'b1; v.pw = 1'b1;
    step(7'($urandom), 1'b1, v, "fetch_ready");
    step(op, 1'($urandom), blank(3'd1), "decode");
    if (!legal(op)) begin
      err_tail();
      return;
    end
    v = blank(3'd2);
    case (op)
      OP_R: v.aop = 2'b10;
      OP_I: begin v.asrc = 1'b1; v.aop = 2'b10; end
      OP_LW, OP_SW: v.asrc = 1'b1;
      OP_BR: begin v.aop = 2'b01; v.br = 1'b1; v.psrc = 1'b1; v.pw = 1'b1; end
      default: begin v.jmp = 1'b1; v.pw = 1'b1; v.psrc = 1'b1; v.asrc = (op == OP_JALR); end
    endcase
    step(7'($urandom), 1'($urandom), v, "exec");
    if (op == OP_BR) return;
    if (op == OP_LW || op == OP_SW) begin
      v = blank(3'd3);
      v.iod = 1'b1;
      v.mr  = (op == OP_LW);
      v.mw  = (op == OP_SW);
      for (int i = 0; i < mw; i++) begin
        step(7'($urandom), 1'b0, v, "mem_wait");
        if (i == TO - 1) begin
          err_tail();
          return;
        end
      end
      step(7'($urandom), 1'b1, v, "mem_ready");
      if (op == OP_SW) return;
    end
    v = blank(3'd4);
    v.rw  = 1'b1;
    v.m2r = (op == OP_LW);
    step(7'($urandom), 1'($urandom), v, "writeback");
  endtask

  function automatic logic [6:0] pick_op(input int k);
    case (k)
      0: return OP_R;
      1: return OP_I;
      2: return OP_LW;
      3: return OP_SW;
      4: return OP_BR;
      5: return OP_JAL;
      6: return OP_JALR;
      default: return 7'($urandom);
    endcase
  endfunction

  function automatic int pick_wait();
    if ($urandom_range(0, 9) == 0) return TO;
    return $urandom_range(0, TO - 1);
  endfunction

  initial begin
    vec_t v;
    @(posedge clk);
    #1;
    do_reset(2);
    run_instr(OP_R, 0, 0);
    run_instr(OP_LW, 0, 3);
    run_instr(OP_SW, 0, 0);
    run_instr(OP_BR, 0, 0);
    run_instr(OP_I, 1, 0);
    run_instr(OP_LW, TO - 1, TO - 1);
    run_instr(OP_R, TO, 0);
    run_instr(OP_SW, 0, TO);
    run_instr(OP_JAL, 0, 0);
    run_instr(OP_JALR, 0, 0);
    run_instr(7'b1111111, 0, 0);

    // Reset in the middle of an SW memory wait.
    v = blank(3'd0);
    v.mr = 1'b1; v.irw = 1'b1; v.pw = 1'b1;
    step(7'($urandom), 1'b1, v, "mid_fetch");
    step(OP_SW, 1'b0, blank(3'd1), "mid_decode");
    v = blank(3'd2);
    v.asrc = 1'b1;
    step(7'($urandom), 1'b0, v, "mid_exec");
    v = blank(3'd3);
    v.iod = 1'b1; v.mw = 1'b1;
    step(7'($urandom), 1'b0, v, "mid_mem");
    step(7'($urandom), 1'b0, v, "mid_mem");
    do_reset(2);
    run_instr(OP_R, 0, 0);

    for (int n = 0; n < 400; n++) run_instr(pick_op($urandom_range(0, 9)), pick_wait(), pick_wait());

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got=%0d exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
